// File: rtl/coin_dispense_sequencer.sv
// ---------------------------------------------------------------------------
// coin_dispense_sequencer
//
// Purpose: drives the quarter/dime/nickel ejector solenoids, one coin at a
// time, from the counts produced by the change calculator. Each coin is a
// PULSE_CYCLES-wide ejector pulse followed by a GAP_CYCLES settle gap. The
// controller side sees a start/busy/done handshake. Quarters go first, then
// dimes, then nickels.
//
// Parameters:
//   PULSE_CYCLES  ejector high time per coin (>=1)
//   GAP_CYCLES    low time after every coin, including the last (>=1)
//   CNT_W         width of each coin-count input
//
// Ports:
//   clk              system clock, rising edge
//   reset_n          synchronous active-low reset
//   start            one-cycle request, counts sampled with it (IDLE only)
//   quarters/dimes/nickels  coin counts to dispense
//   eject_q/d/n      ejector solenoid drives (at most one high)
//   busy             transaction in progress (through the done cycle)
//   done             one-cycle completion pulse
//   coins_remaining  coins not yet fully ejected
//   abort, aborted   only with DISPENSE_ABORT_EN defined: abort request in
//                    PULSE/GAP stops after the current coin; aborted is
//                    raised alongside done for that transaction
//
// Optional feature macro: DISPENSE_ABORT_EN
// ---------------------------------------------------------------------------
module coin_dispense_sequencer #(
    parameter int PULSE_CYCLES = 4,
    parameter int GAP_CYCLES   = 2,
    parameter int CNT_W        = 5
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [CNT_W-1:0] quarters,
    input  logic [CNT_W-1:0] dimes,
    input  logic [CNT_W-1:0] nickels,
    output logic             eject_q,
    output logic             eject_d,
    output logic             eject_n,
    output logic             busy,
    output logic             done,
    output logic [CNT_W+1:0] coins_remaining
`ifdef DISPENSE_ABORT_EN
    ,
    input  logic             abort,
    output logic             aborted
`endif
);

    // One timer serves both the pulse and the gap phase.
    localparam int TMAX = (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
    localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
    localparam logic [TW-1:0] P_LAST = TW'(PULSE_CYCLES - 1);
    localparam logic [TW-1:0] G_LAST = TW'(GAP_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PULSE = 2'd1,
        GAP   = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t           r_state, w_state_nxt;
    logic [CNT_W-1:0] r_q, r_d, r_n;
    logic [CNT_W-1:0] w_q_nxt, w_d_nxt, w_n_nxt;
    logic [CNT_W+1:0] r_rem, w_rem_nxt;
    logic [TW-1:0]    r_timer, w_timer_nxt;
    // {q, d, n} ejector drive; during PULSE it also names the coin in flight
    logic [2:0]       r_ej, w_ej_nxt;
    logic             r_busy, w_busy_nxt;
    logic             r_done, w_done_nxt;
    logic [CNT_W+1:0] w_sum;
    logic             w_abort_any;

    assign w_sum = {2'b00, quarters} + {2'b00, dimes} + {2'b00, nickels};

    // Fixed priority: quarter, dime, nickel.
    function automatic logic [2:0] pick(input logic [CNT_W-1:0] q,
                                        input logic [CNT_W-1:0] d,
                                        input logic [CNT_W-1:0] n);
        logic [2:0] sel;
        sel = 3'b000;
        if (q != '0)      sel = 3'b100;
        else if (d != '0) sel = 3'b010;
        else if (n != '0) sel = 3'b001;
        return sel;
    endfunction

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= IDLE;
            r_q     <= '0;
            r_d     <= '0;
            r_n     <= '0;
            r_rem   <= '0;
            r_timer <= '0;
            r_ej    <= 3'b000;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_q     <= w_q_nxt;
            r_d     <= w_d_nxt;
            r_n     <= w_n_nxt;
            r_rem   <= w_rem_nxt;
            r_timer <= w_timer_nxt;
            r_ej    <= w_ej_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_q_nxt     = r_q;
        w_d_nxt     = r_d;
        w_n_nxt     = r_n;
        w_rem_nxt   = r_rem;
        w_timer_nxt = r_timer;
        w_ej_nxt    = r_ej;
        w_busy_nxt  = r_busy;
        w_done_nxt  = 1'b0;
        case (r_state)
            IDLE: begin
                w_ej_nxt   = 3'b000;
                w_busy_nxt = 1'b0;
                if (start) begin
                    w_q_nxt     = quarters;
                    w_d_nxt     = dimes;
                    w_n_nxt     = nickels;
                    w_rem_nxt   = w_sum;
                    w_timer_nxt = '0;
                    w_busy_nxt  = 1'b1;
                    if (w_sum != '0) begin
                        w_state_nxt = PULSE;
                        // counters load on this same edge, so select from the inputs
                        w_ej_nxt    = pick(quarters, dimes, nickels);
                    end else begin
                        w_state_nxt = DONE;
                        w_done_nxt  = 1'b1;
                    end
                end
            end
            PULSE: begin
                if (r_timer == P_LAST) begin
                    if (r_ej[2]) w_q_nxt = r_q - 1'b1;
                    if (r_ej[1]) w_d_nxt = r_d - 1'b1;
                    if (r_ej[0]) w_n_nxt = r_n - 1'b1;
                    w_rem_nxt   = r_rem - 1'b1;
                    w_ej_nxt    = 3'b000;
                    w_timer_nxt = '0;
                    w_state_nxt = GAP;
                end else begin
                    w_timer_nxt = r_timer + 1'b1;
                end
            end
            GAP: begin
                w_ej_nxt = 3'b000;
                if (r_timer == G_LAST) begin
                    w_timer_nxt = '0;
                    if (r_rem == '0 || w_abort_any) begin
                        w_state_nxt = DONE;
                        w_done_nxt  = 1'b1;
                    end else begin
                        w_state_nxt = PULSE;
                        w_ej_nxt    = pick(r_q, r_d, r_n);
                    end
                end else begin
                    w_timer_nxt = r_timer + 1'b1;
                end
            end
            DONE: begin
                w_ej_nxt    = 3'b000;
                w_busy_nxt  = 1'b0;
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
                w_ej_nxt    = 3'b000;
                w_busy_nxt  = 1'b0;
            end
        endcase
    end

`ifdef DISPENSE_ABORT_EN
    logic r_abort_req;
    logic r_aborted;

    // Sticky request; a pulse arriving in the final gap cycle still counts.
    assign w_abort_any = r_abort_req | (abort & (r_state == PULSE || r_state == GAP));

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_abort_req <= 1'b0;
            r_aborted   <= 1'b0;
        end else begin
            if (r_state == DONE)
                r_abort_req <= 1'b0;
            else if (w_abort_any)
                r_abort_req <= 1'b1;
            r_aborted <= w_done_nxt & w_abort_any;
        end
    end

    assign aborted = r_aborted;
`else
    assign w_abort_any = 1'b0;
`endif

    assign eject_q         = r_ej[2];
    assign eject_d         = r_ej[1];
    assign eject_n         = r_ej[0];
    assign busy            = r_busy;
    assign done            = r_done;
    assign coins_remaining = r_rem;

endmodule
